lvds_pixel_packer: RTL and testbench

Serializes one 18-bit RGB666 pixel plus HSync/VSync/DataEnable into three 7-bit FPD-Link data lanes and a 7-bit clock lane, one bit per cycle. The block runs on the 7x bit clock. It issues a pixel-rate ready strobe to the upstream timing/pattern generator and drives single-ended serial bits that feed the LVDS output buffers. It replaces the vendor serializer path with a portable shift-register implementation.

---
 rtl/lvds_pixel_packer.sv | 85 ++++++++
 tb/tb_lvds_pixel_packer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lvds_pixel_packer.sv
// FPD-Link style pixel packer: maps one RGB666 pixel plus syncs onto three 7-bit
// data lanes and a 7-bit clock lane, shifted out MSB first at the 7x bit clock.
module lvds_pixel_packer #(
  parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
  parameter logic        IDLE_HS     = 1'b1,
  parameter logic        IDLE_VS     = 1'b1,
  parameter int unsigned UNDERRUN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic [5:0]            red,
  input  logic [5:0]            green,
  input  logic [5:0]            blue,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  de,
  output logic                  pix_ready,
  output logic [2:0]            lane_bit,
  output logic                  clk_bit,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam logic [2:0] PH_LAST = 3'd6;
  localparam logic [6:0] BLANK2  = {1'b0, IDLE_VS, IDLE_HS, 4'b0000};

  logic [2:0]            r_ph;
  logic                  r_pix_ready;
  logic [6:0]            r_lane0;
  logic [6:0]            r_lane1;
  logic [6:0]            r_lane2;
  logic [6:0]            r_clk_sr;
  logic [UNDERRUN_W-1:0] r_underrun;

  logic [6:0] w_word0;
  logic [6:0] w_word1;
  logic [6:0] w_word2;

  // Underrun substitutes blanking: black pixel, DE low, syncs at their idle levels.
  always_comb begin
    w_word0 = '0;
    w_word1 = '0;
    w_word2 = BLANK2;
    if (pix_valid) begin
      w_word0 = {green[0], red[5:0]};
      w_word1 = {blue[1:0], green[5:1]};
      w_word2 = {de, vsync, hsync, blue[5:2]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph        <= '0;
      r_pix_ready <= 1'b0;
      r_lane0     <= '0;
      r_lane1     <= '0;
      r_lane2     <= BLANK2;
      r_clk_sr    <= CLK_PATTERN;
      r_underrun  <= '0;
    end else begin
      r_ph        <= (r_ph == PH_LAST) ? 3'd0 : r_ph + 3'd1;
      // Registered so the strobe is high exactly while r_ph == PH_LAST.
      r_pix_ready <= (r_ph == PH_LAST - 3'd1);
      if (r_ph == PH_LAST) begin
        r_lane0  <= w_word0;
        r_lane1  <= w_word1;
        r_lane2  <= w_word2;
        r_clk_sr <= CLK_PATTERN;
        if (!pix_valid && !(&r_underrun))
          r_underrun <= r_underrun + UNDERRUN_W'(1);
      end else begin
        r_lane0  <= {r_lane0[5:0], 1'b0};
        r_lane1  <= {r_lane1[5:0], 1'b0};
        r_lane2  <= {r_lane2[5:0], 1'b0};
        r_clk_sr <= {r_clk_sr[5:0], 1'b0};
      end
    end
  end

  assign pix_ready    = r_pix_ready;
  assign lane_bit     = {r_lane2[6], r_lane1[6], r_lane0[6]};
  assign clk_bit      = r_clk_sr[6];
  assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_lvds_pixel_packer.sv
// Directed bench for lvds_pixel_packer: blanking, single pixel, stream,
// reset placement and counter saturation on a narrow-counter instance.
module tb_lvds_pixel_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [5:0]  red, green, blue;
  logic        hsync, vsync, de;
  logic        pix_ready;
  logic [2:0]  lane_bit;
  logic        clk_bit;
  logic [15:0] underrun_cnt;

  logic        rst4;
  logic        pix_ready4;
  logic [2:0]  lane_bit4;
  logic        clk_bit4;
  logic [3:0]  underrun_cnt4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [6:0] clkp;
  logic [6:0] blank2;
  logic [5:0] v;

  always #5 clk = ~clk;

  lvds_pixel_packer u_dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pix_ready(pix_ready), .lane_bit(lane_bit), .clk_bit(clk_bit),
    .underrun_cnt(underrun_cnt)
  );

  lvds_pixel_packer #(.UNDERRUN_W(4)) u_dut4 (
    .clk(clk), .rst(rst4), .pix_valid(1'b0),
    .red(6'h3F), .green(6'h3F), .blue(6'h3F),
    .hsync(1'b0), .vsync(1'b0), .de(1'b1),
    .pix_ready(pix_ready4), .lane_bit(lane_bit4), .clk_bit(clk_bit4),
    .underrun_cnt(underrun_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Checks the 7 cycles of one slot starting at ph 0; returns at ph 6 without ticking.
  task automatic check_slot(input string tag, input logic [6:0] w2, input logic [6:0] w1,
                            input logic [6:0] w0);
    for (int p = 0; p < 7; p++) begin
      check($sformatf("%s_p%0d", tag, p), {27'd0, pix_ready, clk_bit, lane_bit},
            {27'd0, (p == 6), clkp[6-p], w2[6-p], w1[6-p], w0[6-p]});
      if (p < 6) tick();
    end
  endtask

  task automatic drive_pixel(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                             input logic h, input logic vs, input logic d);
    pix_valid = 1'b1;
    red = r; green = g; blue = b;
    hsync = h; vsync = vs; de = d;
  endtask

  task automatic scramble();
    pix_valid = 1'($urandom);
    red   = 6'($urandom);
    green = 6'($urandom);
    blue  = 6'($urandom);
    hsync = 1'($urandom);
    vsync = 1'($urandom);
    de    = 1'($urandom);
  endtask

  initial begin
    clkp   = 7'b1100011;
    blank2 = 7'b0110000;
    rst = 1'b1; rst4 = 1'b1;
    pix_valid = 1'b0;
    red = '0; green = '0; blue = '0;
    hsync = 1'b0; vsync = 1'b0; de = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_cnt", 32'(underrun_cnt), 32'd0);
    for (int s = 0; s < 3; s++) begin
      check_slot($sformatf("idle%0d", s), blank2, 7'd0, 7'd0);
      tick();
    end
    check("idle_cnt", 32'(underrun_cnt), 32'd3);

    check_slot("pre", blank2, 7'd0, 7'd0);
    drive_pixel(6'h2A, 6'h15, 6'h33, 1'b1, 1'b0, 1'b1);
    tick();
    pix_valid = 1'b0;
    check_slot("pix", 7'b1011100, 7'b1101010, 7'b1101010);
    tick();
    check_slot("after", blank2, 7'd0, 7'd0);
    check("after_cnt", 32'(underrun_cnt), 32'd4);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_cnt", 32'(underrun_cnt), 32'd0);
    check_slot("rst2", blank2, 7'd0, 7'd0);
    for (int k = 0; k < 100; k++) begin
      v = 6'(k % 64);
      drive_pixel(v, v, v, 1'(k), 1'(k >> 1), 1'b1);
      tick();
      scramble();
      check_slot($sformatf("st%0d", k),
                 {1'b1, 1'(k >> 1), 1'(k), v[5:2]}, {v[1:0], v[5:1]}, {v[0], v});
    end
    check("stream_cnt", 32'(underrun_cnt), 32'd0);

    pix_valid = 1'b0;
    tick();
    check_slot("ur", blank2, 7'd0, 7'd0);
    check("ur_cnt", 32'(underrun_cnt), 32'd1);
    drive_pixel(6'h3F, 6'h3F, 6'h3F, 1'b1, 1'b1, 1'b1);
    tick();
    pix_valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      check($sformatf("mid_p%0d", p), {29'd0, lane_bit}, 32'd7);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out", {29'd0, clk_bit, lane_bit[2:1]}, {29'd0, 1'b1, 2'b00});
    check("midrst_l0", {31'd0, lane_bit[0]}, 32'd0);
    check("midrst_cnt", 32'(underrun_cnt), 32'd0);
    check_slot("midrst", blank2, 7'd0, 7'd0);

    rst = 1'b1;
    pix_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("ph6rst_cnt", 32'(underrun_cnt), 32'd0);
    check_slot("ph6rst", blank2, 7'd0, 7'd0);
    drive_pixel(6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pix_valid = 1'b0;
    check_slot("ph6rstv", blank2, 7'd0, 7'd0);
    check("ph6rstv_cnt", 32'(underrun_cnt), 32'd0);

    tick();
    rst4 = 1'b0;
    check("sat_rst", 32'(underrun_cnt4), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      repeat (7) tick();
      check($sformatf("sat%0d", k), 32'(underrun_cnt4), (k < 15) ? 32'(k) : 32'd15);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
